// File: rtl/monster_formation_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : monster_formation_ctrl                                          |
// | Purpose  : Loads, marches, drops and retires the five-monster formation;  |
// |            tracks living monsters and flags win / loss.                   |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module monster_formation_ctrl #(
  parameter int X_INIT    = 250,
  parameter int Y_INIT    = 100,
  parameter int X_SPACING = 100,
  parameter int HALF_W    = 5,
  parameter int HALF_H    = 3,
  parameter int STEP_X    = 4,
  parameter int STEP_Y    = 10,
  parameter int X_MIN     = 150,
  parameter int X_MAX     = 780,
  parameter int Y_FAIL    = 440,
  parameter int MOVE_DIV  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [4:0] kill,
  output logic [9:0] x_base,
  output logic [9:0] y_base,
  output logic [4:0] alive,
  output logic       dir_right,
  output logic       move_pulse,
  output logic       win,
  output logic       lose
);

  // A divider of 1 still needs a one-bit counter so the compare stays legal.
  localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_march = 3'd1;
  localparam logic [2:0] c_st_drop  = 3'd2;
  localparam logic [2:0] c_st_win   = 3'd3;
  localparam logic [2:0] c_st_lose  = 3'd4;

  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(MOVE_DIV - 1);
  localparam logic [9:0]  c_x_init   = 10'(X_INIT);
  localparam logic [9:0]  c_y_init   = 10'(Y_INIT);
  localparam logic [9:0]  c_step_x10 = 10'(STEP_X);
  localparam logic [9:0]  c_step_y10 = 10'(STEP_Y);
  localparam logic [10:0] c_spacing  = 11'(X_SPACING);
  localparam logic [10:0] c_half_w   = 11'(HALF_W);
  localparam logic [10:0] c_half_h   = 11'(HALF_H);
  localparam logic [10:0] c_step_x11 = 11'(STEP_X);
  localparam logic [10:0] c_step_y11 = 11'(STEP_Y);
  localparam logic [10:0] c_x_max    = 11'(X_MAX);
  // Left test is L < X_MIN + STEP_X, folded so no subtraction can wrap.
  localparam logic [10:0] c_x_left   = 11'(X_MIN + STEP_X);
  localparam logic [10:0] c_y_fail   = 11'(Y_FAIL);

  logic [2:0]       r_state;
  logic [DIV_W-1:0] r_div_cnt;

  logic [4:0]       w_alive_k;
  logic [2:0]       w_hi_idx;
  logic [2:0]       w_lo_idx;
  logic [10:0]      w_r_edge;
  logic [10:0]      w_l_edge;
  logic [10:0]      w_y_chk;

  logic [2:0]       w_state_nxt;
  logic [9:0]       w_x_nxt;
  logic [9:0]       w_y_nxt;
  logic [4:0]       w_alive_nxt;
  logic             w_dir_nxt;
  logic             w_pulse_nxt;
  logic [DIV_W-1:0] w_div_nxt;

  assign w_alive_k = alive & ~kill;

  // Locate the outermost survivors (post-kill) to find the formation edges.
  always_comb begin
    w_hi_idx = 3'd0;
    w_lo_idx = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (w_alive_k[i]) w_hi_idx = 3'(i);
    end
    for (int i = 4; i >= 0; i--) begin
      if (w_alive_k[i]) w_lo_idx = 3'(i);
    end
  end

  assign w_r_edge = {1'b0, x_base} + ({8'd0, w_hi_idx} * c_spacing) + c_half_w;
  assign w_l_edge = {1'b0, x_base} + ({8'd0, w_lo_idx} * c_spacing) - c_half_w;
  assign w_y_chk  = {1'b0, y_base} + c_step_y11 + c_half_h;

  // Next-state and next-output decision; start overrides every state.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = x_base;
    w_y_nxt     = y_base;
    w_alive_nxt = alive;
    w_dir_nxt   = dir_right;
    w_pulse_nxt = 1'b0;
    w_div_nxt   = r_div_cnt;
    if (start) begin
      w_state_nxt = c_st_march;
      w_x_nxt     = c_x_init;
      w_y_nxt     = c_y_init;
      w_alive_nxt = 5'b11111;
      w_dir_nxt   = 1'b1;
      w_div_nxt   = '0;
    end else begin
      case (r_state)
        c_st_march: begin
          w_alive_nxt = w_alive_k;
          if (w_alive_k == 5'd0) begin
            w_state_nxt = c_st_win;
          end else if (frame_tick && enable) begin
            if (r_div_cnt == c_div_last) begin
              w_div_nxt = '0;
              if (dir_right) begin
                if ((w_r_edge + c_step_x11) > c_x_max) begin
                  w_state_nxt = c_st_drop;
                end else begin
                  w_x_nxt     = x_base + c_step_x10;
                  w_pulse_nxt = 1'b1;
                end
              end else begin
                if (w_l_edge < c_x_left) begin
                  w_state_nxt = c_st_drop;
                end else begin
                  w_x_nxt     = x_base - c_step_x10;
                  w_pulse_nxt = 1'b1;
                end
              end
            end else begin
              w_div_nxt = r_div_cnt + DIV_W'(1);
            end
          end
        end
        c_st_drop: begin
          w_alive_nxt = w_alive_k;
          if (w_alive_k == 5'd0) begin
            w_state_nxt = c_st_win;
          end else begin
            w_y_nxt     = y_base + c_step_y10;
            w_dir_nxt   = ~dir_right;
            w_pulse_nxt = 1'b1;
            w_state_nxt = (w_y_chk >= c_y_fail) ? c_st_lose : c_st_march;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers; win/lose mirror the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_st_idle;
      r_div_cnt  <= '0;
      x_base     <= c_x_init;
      y_base     <= c_y_init;
      alive      <= 5'd0;
      dir_right  <= 1'b1;
      move_pulse <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_div_cnt  <= w_div_nxt;
      x_base     <= w_x_nxt;
      y_base     <= w_y_nxt;
      alive      <= w_alive_nxt;
      dir_right  <= w_dir_nxt;
      move_pulse <= w_pulse_nxt;
      win        <= (w_state_nxt == c_st_win);
      lose       <= (w_state_nxt == c_st_lose);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_monster_formation_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_monster_formation_ctrl                                       |
// | Purpose  : Self-checking bench for monster_formation_ctrl (two instances: |
// |            default parameters, and STEP_Y=100 / MOVE_DIV=1).              |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_monster_formation_ctrl;

  localparam int X_INIT = 250, Y_INIT = 100, X_SPACING = 100, HALF_W = 5;
  localparam int HALF_H = 3, STEP_X = 4, X_MIN = 150, X_MAX = 780, Y_FAIL = 440;
  localparam int M_IDLE = 0, M_MARCH = 1, M_DROP = 2, M_WIN = 3, M_LOSE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       enable;
  logic       frame_tick;
  logic [4:0] kill;

  logic [9:0] x1, y1, x2, y2;
  logic [4:0] a1, a2;
  logic       d1, p1, w1, l1, d2, p2, w2, l2;

  always #5 clk = ~clk;

  monster_formation_ctrl dut1 (
    .clk(clk), .rst(rst), .start(start), .enable(enable), .frame_tick(frame_tick),
    .kill(kill), .x_base(x1), .y_base(y1), .alive(a1), .dir_right(d1),
    .move_pulse(p1), .win(w1), .lose(l1)
  );

  monster_formation_ctrl #(.STEP_Y(100), .MOVE_DIV(1)) dut2 (
    .clk(clk), .rst(rst), .start(start), .enable(enable), .frame_tick(frame_tick),
    .kill(kill), .x_base(x2), .y_base(y2), .alive(a2), .dir_right(d2),
    .move_pulse(p2), .win(w2), .lose(l2)
  );

  // Behavioural model: positions as integers, edges from the living monsters.
  typedef struct {
    int         mode;
    int         x;
    int         y;
    logic [4:0] alive;
    logic       dir;
    logic       pulse;
    int         div;
  } mdl_t;

  typedef struct {
    logic       st;
    logic       en;
    logic       tk;
    logic [4:0] kl;
    logic [9:0] ex;
    logic [9:0] ey;
    logic [4:0] ea;
    logic       ed;
    logic       ep;
    logic       ew;
    logic       el;
  } vec_t;

  mdl_t m1, m2;
  vec_t tbl[19];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic mdl_t mreset();
    mdl_t r;
    r.mode = M_IDLE; r.x = X_INIT; r.y = Y_INIT; r.alive = 5'd0;
    r.dir = 1'b1; r.pulse = 1'b0; r.div = 0;
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int step_y, int move_div,
                                 logic st, logic en, logic tk, logic [4:0] kl);
    mdl_t       n;
    logic [4:0] surv;
    int         lpx, rpx, px;
    n = m;
    n.pulse = 1'b0;
    if (st) begin
      n.mode = M_MARCH; n.x = X_INIT; n.y = Y_INIT; n.alive = 5'b11111;
      n.dir = 1'b1; n.div = 0;
      return n;
    end
    if (m.mode != M_MARCH && m.mode != M_DROP) return n;
    surv = m.alive & ~kl;
    n.alive = surv;
    if (surv == 5'd0) begin
      n.mode = M_WIN;
      return n;
    end
    if (m.mode == M_DROP) begin
      n.y = m.y + step_y;
      n.dir = ~m.dir;
      n.pulse = 1'b1;
      n.mode = (n.y + HALF_H >= Y_FAIL) ? M_LOSE : M_MARCH;
      return n;
    end
    if (!(en && tk)) return n;
    n.div = m.div + 1;
    if (n.div < move_div) return n;
    n.div = 0;
    lpx = 1 << 30;
    rpx = -(1 << 30);
    for (int i = 0; i < 5; i++) begin
      if (surv[i]) begin
        px = m.x + i * X_SPACING;
        if (px - HALF_W < lpx) lpx = px - HALF_W;
        if (px + HALF_W > rpx) rpx = px + HALF_W;
      end
    end
    if (m.dir) begin
      if (rpx + STEP_X > X_MAX) n.mode = M_DROP;
      else begin n.x = m.x + STEP_X; n.pulse = 1'b1; end
    end else begin
      if (lpx - STEP_X < X_MIN) n.mode = M_DROP;
      else begin n.x = m.x - STEP_X; n.pulse = 1'b1; end
    end
    return n;
  endfunction

  function automatic logic [28:0] mpack(mdl_t m);
    return {10'(m.x), 10'(m.y), m.alive, m.dir, m.pulse,
            (m.mode == M_WIN), (m.mode == M_LOSE)};
  endfunction

  function automatic vec_t mk(logic st, logic en, logic tk, logic [4:0] kl,
                              logic [9:0] ex, logic [9:0] ey, logic [4:0] ea,
                              logic ed, logic ep, logic ew, logic el);
    vec_t v;
    v.st = st; v.en = en; v.tk = tk; v.kl = kl; v.ex = ex; v.ey = ey;
    v.ea = ea; v.ed = ed; v.ep = ep; v.ew = ew; v.el = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [28:0] act, input logic [28:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance both models with the current inputs, compare after the edge.
  task automatic step();
    mdl_t n1, n2;
    n1 = mstep(m1, 10, 8, start, enable, frame_tick, kill);
    n2 = mstep(m2, 100, 1, start, enable, frame_tick, kill);
    @(posedge clk);
    m1 = n1;
    m2 = n2;
    #1;
    check("model_dut1", {x1, y1, a1, d1, p1, w1, l1}, mpack(m1));
    check("model_dut2", {x2, y2, a2, d2, p2, w2, l2}, mpack(m2));
  endtask

  task automatic quiet();
    start = 1'b0; enable = 1'b0; frame_tick = 1'b0; kill = 5'd0;
  endtask

  int moves;
  int guard;

  initial begin
    // Directed vectors: reload, 8-tick divider, enable gating, kill, start priority, win.
    tbl[0]  = mk(1, 0, 0, 5'b00000, 250, 100, 5'h1f, 1, 0, 0, 0);
    for (int i = 1; i < 8; i++)
      tbl[i] = mk(0, 1, 1, 5'b00000, 250, 100, 5'h1f, 1, 0, 0, 0);
    tbl[8]  = mk(0, 1, 1, 5'b00000, 254, 100, 5'h1f, 1, 1, 0, 0);
    tbl[9]  = mk(0, 0, 1, 5'b00000, 254, 100, 5'h1f, 1, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 5'b10000, 254, 100, 5'h0f, 1, 0, 0, 0);
    tbl[11] = mk(1, 1, 1, 5'b00001, 250, 100, 5'h1f, 1, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 5'b00001, 250, 100, 5'h1e, 1, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 5'b00010, 250, 100, 5'h1c, 1, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 5'b00100, 250, 100, 5'h18, 1, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 5'b01000, 250, 100, 5'h10, 1, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 5'b10000, 250, 100, 5'h00, 1, 0, 1, 0);
    tbl[17] = mk(0, 1, 1, 5'b00000, 250, 100, 5'h00, 1, 0, 1, 0);
    tbl[18] = mk(1, 0, 0, 5'b00000, 250, 100, 5'h1f, 1, 0, 0, 0);

    rst = 1'b1;
    quiet();
    m1 = mreset();
    m2 = mreset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_dut1", {x1, y1, a1, d1, p1, w1, l1}, {10'd250, 10'd100, 5'd0, 4'b1000});
    check("reset_dut2", {x2, y2, a2, d2, p2, w2, l2}, {10'd250, 10'd100, 5'd0, 4'b1000});
    rst = 1'b0;
    step();

    for (int i = 0; i < 19; i++) begin
      start = tbl[i].st; enable = tbl[i].en; frame_tick = tbl[i].tk; kill = tbl[i].kl;
      step();
      check($sformatf("vec%0d", i), {x1, y1, a1, d1, p1, w1, l1},
            {tbl[i].ex, tbl[i].ey, tbl[i].ea, tbl[i].ed, tbl[i].ep, tbl[i].ew, tbl[i].el});
    end

    // March right until the edge: 31 moves reach x=374, the next opportunity drops.
    quiet();
    enable = 1'b1; frame_tick = 1'b1;
    moves = 0; guard = 0;
    while (moves < 31 && guard < 400) begin
      step();
      if (p1) moves++;
      guard++;
    end
    check("march_move_count", 29'(moves), 29'd31);
    check("march_x_374", {19'd0, x1}, 29'd374);
    guard = 0;
    while (y1 == 10'd100 && guard < 20) begin
      step();
      guard++;
    end
    check("drop_y_110", {19'd0, y1}, 29'd110);
    check("drop_dir_left", {28'd0, d1}, 29'd0);
    check("drop_x_held", {19'd0, x1}, 29'd374);

    // Rightmost monster killed at once: edge moves in, drop only after 56 moves.
    quiet();
    start = 1'b1;
    step();
    start = 1'b0; enable = 1'b1; frame_tick = 1'b1; kill = 5'b10000;
    moves = 0;
    step();
    if (p1) moves++;
    kill = 5'd0;
    guard = 0;
    while (moves < 56 && guard < 600) begin
      step();
      if (p1) moves++;
      guard++;
    end
    check("shrink_alive", {24'd0, a1}, 29'h0f);
    check("shrink_x_474", {19'd0, x1}, 29'd474);
    guard = 0;
    while (m1.mode != M_DROP && guard < 20) begin
      step();
      guard++;
    end
    check("shrink_no_extra_move", {19'd0, x1}, 29'd474);

    // Asynchronous reset while DUT1 sits in DROP.
    #2 rst = 1'b1;
    #1;
    check("rst_mid_drop_dut1", {x1, y1, a1, d1, p1, w1, l1}, {10'd250, 10'd100, 5'd0, 4'b1000});
    check("rst_mid_drop_dut2", {x2, y2, a2, d2, p2, w2, l2}, {10'd250, 10'd100, 5'd0, 4'b1000});
    m1 = mreset();
    m2 = mreset();
    quiet();
    #2 rst = 1'b0;

    // Loss on the STEP_Y=100 instance: drops to 200, 300, 400, then 500 -> LOSE.
    start = 1'b1;
    step();
    start = 1'b0; enable = 1'b1; frame_tick = 1'b1;
    guard = 0;
    while (!l2 && guard < 2000) begin
      step();
      guard++;
    end
    check("lose_flag", {28'd0, l2}, 29'd1);
    check("lose_y_500", {19'd0, y2}, 29'd500);
    repeat (5) step();
    check("lose_hold_y", {19'd0, y2}, 29'd500);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_after_lose", {x2, y2, a2, d2, p2, w2, l2},
          {10'd250, 10'd100, 5'h1f, 4'b1000});

    // Randomised traffic, compared cycle by cycle against the model.
    start = 1'b1;
    step();
    for (int c = 0; c < 3000; c++) begin
      start      = ($urandom_range(0, 199) == 0);
      enable     = ($urandom_range(0, 9) != 0);
      frame_tick = 1'($urandom_range(0, 1));
      kill       = ($urandom_range(0, 39) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'd0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/monster_formation_ctrl.md
# monster_formation_ctrl

Sequencer for the five-monster formation in the space monsters game. On a start pulse it loads the formation, then marches it horizontally one step every MOVE_DIV frames. It drops the formation one row and reverses direction when the outermost living monster would cross a screen edge. It tracks which monsters are alive and flags win (all destroyed) or loss (formation reached the tank line). It sits between the game state machine (start, enable, kill pulses) and the VGA drawing logic, which draws monster i at x = x_base + i*X_SPACING, y = y_base.

## Interface
- X_INIT, 250: x_base loaded on start (centre of monster 0)
- Y_INIT, 100: y_base loaded on start
- X_SPACING, 100: horizontal pitch between monsters
- HALF_W, 5 / HALF_H, 3: monster half-width / half-height in pixels
- STEP_X, 4 / STEP_Y, 10: horizontal step / drop step in pixels
- X_MIN, 150 / X_MAX, 780: leftmost / rightmost allowed monster pixel
- Y_FAIL, 440: loss line
- MOVE_DIV, 8: frames per horizontal move (≥1)
- Clock and reset: clk and rst. Reset rst is asynchronous, active-high; clock is clk.
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse: (re)load the formation, from any state
- enable  in  1  level: movement allowed (game in L1)
- frame_tick  in  1  one-cycle pulse per video frame
- kill  in  5  one-cycle pulse per monster hit; bit i = monster i
- x_base  out  10  centre x of monster 0
- y_base  out  10  centre y of all monsters
- alive  out  5  living-monster mask
- dir_right  out  1  1 = marching right
- move_pulse  out  1  one-cycle pulse on each horizontal step or drop
- win  out  1  high in state WIN
- lose  out  1  high in state LOSE

## Operation
- States: IDLE, MARCH, DROP, WIN, LOSE. All outputs are registered.
- Reset values: state IDLE, x_base=X_INIT, y_base=Y_INIT, alive=0, dir_right=1, move_pulse=0, win=0, lose=0, div_cnt=0.
- start has priority over everything except rst, in any state:
  - loads x_base=X_INIT, y_base=Y_INIT, alive=5'b11111, dir_right=1, div_cnt=0
  - next state is MARCH
- Kill handling:
  - In MARCH and DROP: alive <= alive & ~kill every cycle.
  - In IDLE, WIN and LOSE: kill is ignored.
  - If (alive & ~kill)==0 in MARCH or DROP, next state is WIN. This overrides any move or drop in that cycle.
- MARCH, on each frame_tick with enable=1:
  - If div_cnt==MOVE_DIV-1, set div_cnt=0 and evaluate a move. Otherwise div_cnt increments.
  - With enable=0, div_cnt holds.
- Move evaluation:
  - Uses the alive mask after this cycle's kills.
  - r = highest alive index, l = lowest alive index.
  - Edges are computed in 11 bits (no wrap): R = x_base + r*X_SPACING + HALF_W, L = x_base + l*X_SPACING − HALF_W.
  - Right: if R+STEP_X > X_MAX, go to DROP. Otherwise x_base += STEP_X and pulse move_pulse.
  - Left: if L < X_MIN+STEP_X, go to DROP. Otherwise x_base −= STEP_X and pulse move_pulse.
- DROP, lasting exactly one cycle:
  - y_base += STEP_Y, dir_right toggles, move_pulse=1.
  - If y_base+STEP_Y+HALF_H ≥ Y_FAIL, next state is LOSE. Otherwise next state is MARCH.
  - frame_tick arriving in DROP is ignored: no div_cnt change.
- WIN and LOSE hold all position outputs until start. IDLE likewise waits for start.

## Timing
- start sampled at cycle n: loaded values and state MARCH are visible at n+1.
- Horizontal move: frame_tick at cycle t → x_base and move_pulse updated at t+1.
- Drop: frame_tick at t → state DROP at t+1 → y_base/dir_right updated and state MARCH or LOSE at t+2.
- Kill at t → alive updated at t+1; win asserted at t+1 if it was the last monster.
- Simultaneous events:
  - A kill and a move trigger in the same cycle: the edge check uses the post-kill mask.
  - start coincident with kill or frame_tick: start wins.
- rst mid-operation forces the reset values immediately (asynchronous).

## Test plan
- **Reset/start:** assert rst, release, pulse start → x_base=250, y_base=100, alive=11111, dir_right=1, win=lose=0 one cycle after start.
- **March to right edge**, defaults, enable=1, 8 ticks per move:
  - after 31 moves, x_base=374 (R=779)
  - the 32nd move opportunity enters DROP → y_base=110, dir_right=0, x_base stays 374
- **Edge shrink:** kill=5'b10000 right after start → alive=01111, R=x_base+305. The drop occurs only after 56 right moves (x_base=474, R=779).
- **Win:** kill bits one per cycle, 00001..10000 → alive reaches 0 and win=1 one cycle after the last kill. Further ticks leave x_base unchanged.
- **Lose:** STEP_Y=100, Y_FAIL=440 → after drops y_base=200,300,400, the 4th drop gives y_base=500, which is ≥437, so lose=1.
- **Enable/priority:** enable=0 with ticks → div_cnt and x_base frozen. start during LOSE → reload to 250/100 and MARCH. rst asserted mid-DROP → reset values immediately.
